phasediff_sched: RTL and testbench
==================================

Name: phasediff_sched

Overview:
- Time-multiplexes one shared phasediff unit across NCH receiver phase channels.
- On each sample strobe it snapshots all channel phases and issues one (channel, reference) pair per cycle to the shared unit.
- It tags each in-flight result, collects the results, and presents a coherent set of phase differences with a one-cycle valid pulse.
- Sits between the per-receiver phase extractors and the direction-estimation logic.

Parameters:
W, 19, phase/difference word width, signed Q8.10 (FRAC=10)
NCH, 4, number of receiver channels (2..8)
PD_LATENCY, 1, cycles from pd_sample to valid pd_out of the shared phasediff (1..4)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on clock edge)
start  in  1  sample strobe: new phase set on phase_in
phase_in  in  NCH*W  channel k at bits [k*W +: W]
ref_sel  in  $clog2(NCH)  reference channel index, latched on accepted start
busy  out  1  high while a set is in progress
pd_sample  out  1  issue strobe to shared phasediff
pd_A  out  W  minuend phase to phasediff
pd_B  out  W  subtrahend (reference) phase to phasediff
pd_out  in  W  phasediff result, valid PD_LATENCY cycles after pd_sample
diff_out  out  NCH*W  slot k = phase[k] - phase[ref]; ref slot = 0
diff_valid  out  1  one-cycle pulse: diff_out updated
overrun  out  1  one-cycle pulse: start dropped because busy

Behaviour:
- Reset state: FSM IDLE, tag pipe cleared. busy, pd_sample, pd_A, pd_B, diff_out, diff_valid and overrun are all 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1:
  - snapshot phase_in and ref_sel.
  - ref_sel >= NCH is treated as 0.
  - next state ISSUE, channel index at lowest k != ref.
- ISSUE, one pair per cycle:
  - pd_sample=1, pd_A=snap[k], pd_B=snap[ref].
  - Push tag {1,k} into a PD_LATENCY-deep tag pipe.
  - Channels are issued in ascending k, skipping ref: NCH-1 issues in total.
  - After the last issue, go to DRAIN.
- Outside ISSUE: pd_sample=0 and pd_A/pd_B are driven 0.
- Result capture: when the tag pipe output is valid, work[idx] <= pd_out, in any state.
- DRAIN: wait until the tag pipe is empty, then go to DONE.
- DONE:
  - diff_out <= work, with the ref slot forced to 0.
  - diff_valid=1 for this cycle only.
  - next state IDLE.
- diff_out holds between pulses.
- Timing, with start high in cycle 0:
  - pd_sample high in cycles 1..NCH-1.
  - diff_valid in cycle NCH+PD_LATENCY.
  - busy high in cycles 1..NCH+PD_LATENCY.
  - The next start is accepted from cycle NCH+PD_LATENCY+1.
- start while busy:
  - ignored: no snapshot change, no effect on the in-flight set.
  - overrun pulses in the same cycle, registered one cycle later.
- Reset mid-operation: returns to the reset state immediately. Any in-flight set is discarded; no diff_valid is produced.
- No arithmetic in this block: values are passed through at full W width, no sign extension or truncation.

Optional Feature:
PHASEDIFF_SCHED_OVRCNT_EN
- Defined:
  - adds output ovr_cnt[7:0], counting dropped starts.
  - saturates at 255; cleared by reset.
  - bit widths of all other ports are unchanged.
- Undefined: the port and counter are absent; overrun pulse behaviour is identical in both cases.

Decomposition:
- Package phasediff_pkg:
  - PD_W=19, PD_FRAC=10, PD_NCH=4 constants.
  - state enum typedef {IDLE, ISSUE, DRAIN, DONE}.
  - channel-index width constant $clog2(PD_NCH).
- Sub-module pd_tag_pipe: parameterised PD_LATENCY-deep shift register of {valid, idx}, with a synchronous active-low clear.
- Issue and capture logic stay in phasediff_sched.

Test Plan:
Bench model: pd_out = A-B, registered by PD_LATENCY cycles.
- Reset, then start in cycle 0 with ch0=0x00400, ch1=0x00C00, ch2=0x00000, ch3=0x7FC00, ref_sel=0 -> pd_sample in cycles 1-3 (pd_A = ch1, ch2, ch3; pd_B = 0x00400); diff_valid in cycle 5; diff_out = {0, 0x00800, 0x7FC00, 0x7F800}.
- Same phases, ref_sel=2 -> pd_A order ch0, ch1, ch3 with pd_B=0x00000; diff_out = {0x00400, 0x00C00, 0, 0x7FC00}.
- Second start in cycle 3 with different phases -> overrun pulse, results identical to test 1; start in cycle 6 -> accepted, diff_valid in cycle 11.
- reset=0 in cycle 2 of a set -> all outputs 0 next cycle, no diff_valid; the following start completes normally.
- PD_LATENCY=3 -> diff_valid in cycle 7, busy cycles 1-7, correct slot mapping; with PHASEDIFF_SCHED_OVRCNT_EN, 300 busy starts -> ovr_cnt=255.

Source files
------------

// File: rtl/phasediff_pkg.sv
// Shared constants and FSM state type for the phasediff scheduler slice.
package phasediff_pkg;

  localparam int PD_W     = 19;
  localparam int PD_FRAC  = 10;
  localparam int PD_NCH   = 4;
  localparam int PD_IDX_W = $clog2(PD_NCH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pd_state_e;

endpackage

// File: rtl/pd_tag_pipe.sv
// DEPTH-deep shift register of {valid, idx} tags that tracks results in flight
// through the shared phasediff unit; synchronous active-low clear.
module pd_tag_pipe
  import phasediff_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int IW    = PD_IDX_W
) (
  input  logic          clock,
  input  logic          clr_b,
  input  logic          push_valid,
  input  logic [IW-1:0] push_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          pending
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][IW-1:0] idx_q, idx_d;

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    valid_d[0] = push_valid;
    idx_d[0]   = push_idx;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      idx_d[i]   = idx_q[i-1];
    end
    // Tags not yet at the output stage; the output stage is consumed this cycle.
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | valid_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!clr_b) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/phasediff_sched.sv
// Time-multiplexes one shared phasediff unit across NCH phase channels.
// Optional PHASEDIFF_SCHED_OVRCNT_EN adds a saturating dropped-start counter (ovr_cnt).
//
// state | meaning
// IDLE  | waiting for start, snapshot taken on accept
// ISSUE | one (channel, ref) pair per cycle to the shared unit
// DRAIN | waiting for the last results to return
// DONE  | diff_out freshly loaded, diff_valid pulse
module phasediff_sched
  import phasediff_pkg::*;
#(
  parameter int  W          = PD_W,
  parameter int  NCH        = PD_NCH,
  parameter int  PD_LATENCY = 1,
  localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NCH*W-1:0] phase_in,
  input  logic [IW-1:0]    ref_sel,
  output logic             busy,
  output logic             pd_sample,
  output logic [W-1:0]     pd_A,
  output logic [W-1:0]     pd_B,
  input  logic [W-1:0]     pd_out,
  output logic [NCH*W-1:0] diff_out,
  output logic             diff_valid,
  output logic             overrun
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
  ,
  output logic [7:0]       ovr_cnt
`endif
);

  pd_state_e             state_q, state_d;
  logic [NCH-1:0][W-1:0] snap_q, snap_d;
  logic [NCH-1:0][W-1:0] work_q, work_d;
  logic [NCH-1:0][W-1:0] diff_q, diff_d;
  logic [IW-1:0]         ref_q, ref_d;
  logic [IW:0]           ch_q, ch_d;
  logic                  overrun_q, overrun_d;

  logic [IW:0]           ch_nxt;
  logic                  ch_last;
  logic [IW-1:0]         ref_lat;
  logic [IW:0]           ch_first;

  logic                  push_valid;
  logic [IW-1:0]         push_idx;
  logic                  tag_out_valid;
  logic [IW-1:0]         tag_out_idx;
  logic                  tag_pending;

  pd_tag_pipe #(
    .DEPTH (PD_LATENCY),
    .IW    (IW)
  ) u_tag_pipe (
    .clock      (clock),
    .clr_b      (reset),
    .push_valid (push_valid),
    .push_idx   (push_idx),
    .out_valid  (tag_out_valid),
    .out_idx    (tag_out_idx),
    .pending    (tag_pending)
  );

  always_comb begin
    ref_lat  = (32'(ref_sel) >= NCH) ? '0 : ref_sel;
    ch_first = (ref_lat == '0) ? (IW+1)'(1) : '0;

    ch_nxt = ch_q + (IW+1)'(1);
    if (ch_nxt == {1'b0, ref_q}) begin
      ch_nxt = ch_nxt + (IW+1)'(1);
    end
    ch_last = (ch_nxt >= (IW+1)'(NCH));
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    work_d     = work_q;
    diff_d     = diff_q;
    ref_d      = ref_q;
    ch_d       = ch_q;
    overrun_d  = start && (state_q != IDLE);
    pd_sample  = 1'b0;
    pd_A       = '0;
    pd_B       = '0;
    push_valid = 1'b0;
    push_idx   = ch_q[IW-1:0];
    diff_valid = 1'b0;

    if (tag_out_valid) begin
      work_d[tag_out_idx] = pd_out;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = phase_in;
          ref_d   = ref_lat;
          ch_d    = ch_first;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        pd_sample  = 1'b1;
        pd_A       = snap_q[ch_q[IW-1:0]];
        pd_B       = snap_q[ref_q];
        push_valid = 1'b1;
        ch_d       = ch_nxt;
        if (ch_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Load diff_out on the way into DONE so it changes with the valid pulse;
        // work_d already holds any result landing this cycle.
        if (!tag_pending) begin
          diff_d        = work_d;
          diff_d[ref_q] = '0;
          state_d       = DONE;
        end
      end
      DONE: begin
        diff_valid = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      work_q    <= '0;
      diff_q    <= '0;
      ref_q     <= '0;
      ch_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      work_q    <= work_d;
      diff_q    <= diff_d;
      ref_q     <= ref_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign diff_out = diff_q;
  assign overrun  = overrun_q;

`ifdef PHASEDIFF_SCHED_OVRCNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_phasediff_sched.sv
// Scoreboard bench for phasediff_sched: two instances (PD_LATENCY 1 and 3) share stimulus,
// each fed by its own A-B result pipe. Define PHASEDIFF_SCHED_OVRCNT_EN to also cover ovr_cnt.
module tb_phasediff_sched;
  localparam int W   = 19;
  localparam int NCH = 4;
  localparam int DW  = NCH * W;

  localparam logic [DW-1:0] P1 = {19'h7FC00, 19'h00000, 19'h00C00, 19'h00400};
  localparam logic [DW-1:0] P2 = {19'h12345, 19'h00001, 19'h40000, 19'h3FFFF};
  localparam logic [DW-1:0] T1 = {19'h7F800, 19'h7FC00, 19'h00800, 19'h00000};
  localparam logic [DW-1:0] T2 = {19'h7FC00, 19'h00000, 19'h00C00, 19'h00400};

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] phase_in = '0;
  logic [1:0]    ref_sel = '0;

  logic          busy_o       [2];
  logic          pd_sample_o  [2];
  logic [W-1:0]  pd_a_o       [2];
  logic [W-1:0]  pd_b_o       [2];
  logic [W-1:0]  pd_out_i     [2];
  logic [DW-1:0] diff_o       [2];
  logic          diff_valid_o [2];
  logic          overrun_o    [2];
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
  logic [7:0]    ovr_cnt_o    [2];
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  always #5 clock = ~clock;

  phasediff_sched #(.W(W), .NCH(NCH), .PD_LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .start(start), .phase_in(phase_in), .ref_sel(ref_sel),
    .busy(busy_o[0]), .pd_sample(pd_sample_o[0]), .pd_A(pd_a_o[0]), .pd_B(pd_b_o[0]),
    .pd_out(pd_out_i[0]), .diff_out(diff_o[0]), .diff_valid(diff_valid_o[0]),
    .overrun(overrun_o[0])
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
    , .ovr_cnt(ovr_cnt_o[0])
`endif
  );

  phasediff_sched #(.W(W), .NCH(NCH), .PD_LATENCY(3)) dut_l3 (
    .clock(clock), .reset(reset), .start(start), .phase_in(phase_in), .ref_sel(ref_sel),
    .busy(busy_o[1]), .pd_sample(pd_sample_o[1]), .pd_A(pd_a_o[1]), .pd_B(pd_b_o[1]),
    .pd_out(pd_out_i[1]), .diff_out(diff_o[1]), .diff_valid(diff_valid_o[1]),
    .overrun(overrun_o[1])
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
    , .ovr_cnt(ovr_cnt_o[1])
`endif
  );

  // Shared-unit model: pd_out = A - B, delayed by the instance latency.
  logic [W-1:0] pd_pipe [2][3];
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      pd_pipe[d][2] <= pd_pipe[d][1];
      pd_pipe[d][1] <= pd_pipe[d][0];
      pd_pipe[d][0] <= pd_a_o[d] - pd_b_o[d];
    end
  end
  assign pd_out_i[0] = pd_pipe[0][0];
  assign pd_out_i[1] = pd_pipe[1][2];

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard state per instance.
  int              lat     [2];
  int              cnt     [2];
  logic            ovr_exp [2];
  int              ovr_mdl [2];
  logic [DW-1:0]   last_diff [2];
  logic [2*W-1:0]  q_pd [2][$];
  logic [DW-1:0]   q_df [2][$];
  logic [2*W-1:0]  e_pd;
  logic [DW-1:0]   e_df;

  initial begin
    lat[0] = 1;
    lat[1] = 3;
  end

  task automatic push_set(input int d);
    logic [NCH-1:0][W-1:0] ph;
    logic [NCH-1:0][W-1:0] ex;
    int r;
    ph = phase_in;
    r  = (int'(ref_sel) >= NCH) ? 0 : int'(ref_sel);
    for (int k = 0; k < NCH; k++) begin
      if (k == r) begin
        ex[k] = '0;
      end else begin
        ex[k] = ph[k] - ph[r];
        q_pd[d].push_back({ph[k], ph[r]});
      end
    end
    q_df[d].push_back(ex);
  endtask

  // Behavioural model: a set occupies NCH+latency cycles after the accepting edge.
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        cnt[d]       = 0;
        ovr_exp[d]   = 1'b0;
        ovr_mdl[d]   = 0;
        last_diff[d] = '0;
        q_pd[d].delete();
        q_df[d].delete();
      end else begin
        ovr_exp[d] = start && (cnt[d] != 0);
        if (ovr_exp[d] && ovr_mdl[d] < 255) ovr_mdl[d]++;
        if (cnt[d] != 0) begin
          cnt[d]--;
        end else if (start) begin
          cnt[d] = NCH + lat[d];
          push_set(d);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[%0d]", d), DW'(busy_o[d]), DW'(cnt[d] != 0));
        chk($sformatf("pd_sample[%0d]", d), DW'(pd_sample_o[d]),
            DW'((cnt[d] >= lat[d] + 2) && (cnt[d] <= NCH + lat[d])));
        chk($sformatf("diff_valid[%0d]", d), DW'(diff_valid_o[d]), DW'(cnt[d] == 1));
        chk($sformatf("overrun[%0d]", d), DW'(overrun_o[d]), DW'(ovr_exp[d]));
        if (pd_sample_o[d]) begin
          if (q_pd[d].size() == 0) begin
            chk($sformatf("pd_queue[%0d]", d), DW'(q_pd[d].size()), DW'(1));
          end else begin
            e_pd = q_pd[d].pop_front();
            chk($sformatf("pd_A[%0d]", d), DW'(pd_a_o[d]), DW'(e_pd[2*W-1:W]));
            chk($sformatf("pd_B[%0d]", d), DW'(pd_b_o[d]), DW'(e_pd[W-1:0]));
          end
        end else begin
          chk($sformatf("pd_idle[%0d]", d), DW'({pd_a_o[d], pd_b_o[d]}), '0);
        end
        if (diff_valid_o[d]) begin
          if (q_df[d].size() == 0) begin
            chk($sformatf("diff_queue[%0d]", d), DW'(q_df[d].size()), DW'(1));
          end else begin
            e_df = q_df[d].pop_front();
            chk($sformatf("diff_out[%0d]", d), diff_o[d], e_df);
            last_diff[d] = e_df;
          end
        end else begin
          chk($sformatf("diff_hold[%0d]", d), diff_o[d], last_diff[d]);
        end
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
        chk($sformatf("ovr_cnt[%0d]", d), DW'(ovr_cnt_o[d]), DW'(ovr_mdl[d]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [DW-1:0] ph, input logic [1:0] rs);
    start    = 1'b1;
    phase_in = ph;
    ref_sel  = rs;
    tick();
    start    = 1'b0;
    phase_in = DW'({$urandom, $urandom, $urandom});
    ref_sel  = 2'($urandom);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    wait_cycles(3);
    mon_en = 1'b1;
    @(negedge clock);
    chk("reset_diff0", diff_o[0], '0);
    chk("reset_busy0", DW'(busy_o[0]), '0);
    reset = 1'b1;
    tick();

    // Reference channel 0, then reference channel 2.
    pulse_start(P1, 2'd0);
    wait_cycles(10);
    chk("t1_diff_l1", diff_o[0], T1);
    chk("t1_diff_l3", diff_o[1], T1);
    pulse_start(P1, 2'd2);
    wait_cycles(10);
    chk("t2_diff_l1", diff_o[0], T2);
    chk("t2_diff_l3", diff_o[1], T2);

    // Start at cycle 3 dropped; start at cycle 6 taken only by the latency-1 instance.
    pulse_start(P1, 2'd0);
    wait_cycles(2);
    pulse_start(P2, 2'd1);
    wait_cycles(2);
    pulse_start(P2, 2'd1);
    @(negedge clock);
    chk("t3_diff_l1", diff_o[0], T1);
    chk("t3_diff_l3", diff_o[1], T1);
    wait_cycles(12);

    // Reset in cycle 2 of a set discards it.
    pulse_start(P2, 2'd3);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("rst_mid_diff_l1", diff_o[0], '0);
    chk("rst_mid_busy_l3", DW'(busy_o[1]), '0);
    reset = 1'b1;
    tick();
    pulse_start(P1, 2'd1);
    wait_cycles(10);

    for (int i = 0; i < 6; i++) begin
      pulse_start(DW'({$urandom, $urandom, $urandom}), 2'($urandom));
      wait_cycles(9 + int'($urandom_range(0, 2)));
    end

    // Start held high: back-to-back sets with drops in between.
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
    for (int i = 0; i < 400; i++) begin
`else
    for (int i = 0; i < 30; i++) begin
`endif
      start    = 1'b1;
      phase_in = DW'({$urandom, $urandom, $urandom});
      ref_sel  = 2'($urandom);
      tick();
    end
    start = 1'b0;
    wait_cycles(12);
`ifdef PHASEDIFF_SCHED_OVRCNT_EN
    chk("ovr_sat_l1", DW'(ovr_cnt_o[0]), DW'(255));
    chk("ovr_sat_l3", DW'(ovr_cnt_o[1]), DW'(255));
`endif

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pd_left[%0d]", d), DW'(q_pd[d].size()), '0);
      chk($sformatf("diff_left[%0d]", d), DW'(q_df[d].size()), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
